// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler slice:
// opcodes, scheduler states and the opcode legality check.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one
// past the previous winner and wraps modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  int idx;

  // first requester after last_grant wins
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any && req[idx[IDW-1:0]]) begin
        any                  = 1'b1;
        grant[idx[IDW-1:0]] = 1'b1;
        grant_id             = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one registered ALU among NREQ requesters:
// accept, issue, wait out ALU latency, return result.
module alu_sched
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_zero,
  output logic                  resp_illegal,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_control,
  input  logic [WIDTH-1:0]      alu_result
);

  localparam int IDW = $clog2(NREQ);

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic [NREQ-1:0]  arb_grant;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_q),
    .grant     (arb_grant),
    .grant_id  (arb_id),
    .any       (arb_any)
  );

  // FSM next state, register loads and handshakes
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    zero_d     = zero_q;
    ill_d      = ill_q;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (!rst) req_ready = arb_grant;
        if (arb_any) begin
          a_d     = req_a[int'(arb_id)*WIDTH +: WIDTH];
          b_d     = req_b[int'(arb_id)*WIDTH +: WIDTH];
          op_d    = req_op[int'(arb_id)*3 +: 3];
          gnt_d   = arb_id;
          last_d  = arb_id;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        res_d   = alu_result;
        zero_d  = (alu_result == '0);
        ill_d   = !op_legal(op_q);
        state_d = RESP;
      end
      RESP: begin
        resp_valid[gnt_q] = 1'b1;
        if (resp_ready[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, reset has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ-1);
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_control  = op_q;
  assign resp_result  = res_q;
  assign resp_zero    = zero_q;
  assign resp_illegal = ill_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: registered ALU model plus
// directed and randomized scenarios against a reference.
module tb_alu_sched;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_OR  = 3'b001;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b011;
  localparam logic [2:0] C_MUL = 3'b111;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ-1:0]       resp_valid, resp_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ*3-1:0]     req_op;
  logic [WIDTH-1:0]      resp_result;
  logic                  resp_zero, resp_illegal;
  logic [WIDTH-1:0]      alu_a, alu_b, alu_result;
  logic [2:0]            alu_control;

  int checks = 0;
  int errors = 0;
  int last_model;

  always #5 clk = ~clk;

  alu_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_illegal(resp_illegal),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result)
  );

  function automatic logic [WIDTH-1:0] ref_alu(
    input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      C_AND:   ref_alu = a & b;
      C_OR:    ref_alu = a | b;
      C_ADD:   ref_alu = a + b;
      C_SUB:   ref_alu = a - b;
      C_MUL:   ref_alu = a * b;
      default: ref_alu = '0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [2:0] op);
    return (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // the shared ALU: result registered one cycle after inputs
  always @(posedge clk) alu_result <= ref_alu(alu_control, alu_a, alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*3 +: 3]        = op;
    req_valid[i]            = 1'b1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (resp_valid == '0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic serve_pending(input int nops);
    for (int k = 0; k < nops; k++) begin
      int w, n;
      logic [NREQ-1:0] oh;
      logic [2:0] op;
      logic [WIDTH-1:0] a, b, r;
      #1;
      w = rr_pick(req_valid, last_model);
      checks++;
      if (w < 0) begin
        errors++;
        $display("FAIL serve_none: no pending request, req_ready=%b", req_ready);
        return;
      end
      oh = '0;
      oh[w] = 1'b1;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL serve_grant: req_ready=%b expected %b", req_ready, oh);
      end
      op = req_op[w*3 +: 3];
      a  = req_a[w*WIDTH +: WIDTH];
      b  = req_b[w*WIDTH +: WIDTH];
      r  = ref_alu(op, a, b);
      tick();
      last_model = w;
      wait_resp(n);
      checks++;
      if (n != 2 || resp_valid !== oh) begin
        errors++;
        $display("FAIL serve_latency: resp_valid=%b after %0d cycles, expected %b after 2",
                 resp_valid, n, oh);
      end
      checks++;
      if (resp_result !== r || resp_zero !== (r == '0) ||
          resp_illegal !== ref_illegal(op)) begin
        errors++;
        $display("FAIL serve_result: got %0h z%b i%b expected %0h z%b i%b",
                 resp_result, resp_zero, resp_illegal, r, (r == '0), ref_illegal(op));
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    resp_ready = '0;
    set_req(0, C_ADD, $urandom, $urandom);
    set_req(1, C_OR, $urandom, $urandom);
    tick();
    tick();
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    checks++;
    if (resp_valid !== '0 || alu_a !== '0 || alu_b !== '0 || alu_control !== 3'b000) begin
      errors++;
      $display("FAIL reset_alu: rv=%b a=%0h b=%0h ctl=%b expected all 0",
               resp_valid, alu_a, alu_b, alu_control);
    end
    checks++;
    if (resp_result !== '0 || resp_zero !== 1'b0 || resp_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: res=%0h z=%b i=%b expected 0",
               resp_result, resp_zero, resp_illegal);
    end
    req_valid  = '0;
    rst        = 1'b0;
    last_model = NREQ - 1;
    tick();
  endtask

  task automatic test_single();
    resp_ready = '1;
    set_req(0, C_ADD, 5, 7);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    tick();
    req_valid = '0;
    last_model = 0;
    checks++;
    if (alu_a !== 5 || alu_b !== 7 || alu_control !== C_ADD || req_ready !== '0) begin
      errors++;
      $display("FAIL single_issue: a=%0h b=%0h ctl=%b rdy=%b expected 5 7 010 00",
               alu_a, alu_b, alu_control, req_ready);
    end
    tick();
    checks++;
    if (resp_valid !== '0) begin
      errors++;
      $display("FAIL single_early: resp_valid=%b expected 00", resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 2'b01 || resp_result !== 12 ||
        resp_zero !== 1'b0 || resp_illegal !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: rv=%b res=%0d z=%b i=%b expected 01 12 0 0",
               resp_valid, resp_result, resp_zero, resp_illegal);
    end
    tick();
    checks++;
    if (resp_valid !== '0) begin
      errors++;
      $display("FAIL single_done: resp_valid=%b expected 00", resp_valid);
    end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    resp_ready = '1;
    set_req(0, C_SUB, 9, 9);
    set_req(1, C_OR, 32'hF0, 32'h0F);
    tick();
    rst = 1'b0;
    last_model = NREQ - 1;
    serve_pending(3);
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    resp_ready = 2'b01;
    set_req(1, C_MUL, 6, 7);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_ready: got %b expected 10", req_ready);
    end
    tick();
    last_model = 1;
    req_valid = '0;
    wait_resp(n);
    checks++;
    if (n != 2 || resp_valid !== 2'b10) begin
      errors++;
      $display("FAIL bp_latency: rv=%b after %0d expected 10 after 2", resp_valid, n);
    end
    set_req(0, C_ADD, 1, 2);
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 2'b10 || resp_result !== 42 || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b res=%0d rdy=%b expected 10 42 00",
                 i, resp_valid, resp_result, req_ready);
      end
      tick();
    end
    resp_ready = 2'b10;
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== '0) begin
      errors++;
      $display("FAIL bp_release: resp_valid=%b expected 00", resp_valid);
    end
    tick();
    tick();
    checks++;
    if (alu_a !== 6 || alu_control !== C_MUL || resp_valid !== '0) begin
      errors++;
      $display("FAIL bp_withdraw: a=%0h ctl=%b rv=%b expected 6 111 00",
               alu_a, alu_control, resp_valid);
    end
  endtask

  task automatic test_illegal();
    resp_ready = '1;
    set_req(0, 3'b101, 3, 4);
    serve_pending(1);
    checks++;
    if (alu_control !== 3'b101 || resp_valid !== '0) begin
      errors++;
      $display("FAIL illegal_issue: ctl=%b rv=%b expected 101 00", alu_control, resp_valid);
    end
  endtask

  task automatic test_reset_midop();
    resp_ready = '1;
    set_req(0, C_ADD, 1, 1);
    #1;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_model = NREQ - 1;
    checks++;
    if (resp_valid !== '0 || alu_a !== '0 || alu_control !== 3'b000 || resp_result !== '0) begin
      errors++;
      $display("FAIL midrst_state: rv=%b a=%0h ctl=%b res=%0h expected 0",
               resp_valid, alu_a, alu_control, resp_result);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (resp_valid !== '0) begin
        errors++;
        $display("FAIL midrst_noresp%0d: resp_valid=%b expected 00", i, resp_valid);
      end
    end
    set_req(0, C_AND, 32'hC, 32'hA);
    set_req(1, C_ADD, 100, 23);
    serve_pending(2);
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int w, n, d;
      logic [NREQ-1:0] oh;
      logic [2:0] op;
      logic [WIDTH-1:0] a, b, r;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
          else
            set_req(i, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      w = rr_pick(req_valid, last_model);
      checks++;
      if (w < 0) begin
        if (req_ready !== '0) begin
          errors++;
          $display("FAIL rnd_idle: req_ready=%b expected 00", req_ready);
        end
        tick();
        continue;
      end
      oh = '0;
      oh[w] = 1'b1;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL rnd_grant: req_ready=%b expected %b", req_ready, oh);
      end
      op = req_op[w*3 +: 3];
      a  = req_a[w*WIDTH +: WIDTH];
      b  = req_b[w*WIDTH +: WIDTH];
      r  = ref_alu(op, a, b);
      d  = $urandom_range(0, 3);
      resp_ready = NREQ'($urandom);
      resp_ready[w] = (d == 0);
      tick();
      last_model = w;
      req_valid[w] = 1'b0;
      wait_resp(n);
      checks++;
      if (n != 2 || resp_valid !== oh) begin
        errors++;
        $display("FAIL rnd_latency: rv=%b after %0d expected %b after 2", resp_valid, n, oh);
      end
      checks++;
      if (resp_result !== r || resp_zero !== (r == '0) ||
          resp_illegal !== ref_illegal(op)) begin
        errors++;
        $display("FAIL rnd_result: op=%b got %0h z%b i%b expected %0h z%b i%b",
                 op, resp_result, resp_zero, resp_illegal, r, (r == '0), ref_illegal(op));
      end
      for (int j = 0; j < d; j++) begin
        tick();
        checks++;
        if (resp_valid !== oh || resp_result !== r || req_ready !== '0) begin
          errors++;
          $display("FAIL rnd_hold: rv=%b res=%0h rdy=%b expected %b %0h 00",
                   resp_valid, resp_result, req_ready, oh, r);
        end
      end
      resp_ready[w] = 1'b1;
      tick();
      checks++;
      if (resp_valid !== '0) begin
        errors++;
        $display("FAIL rnd_done: resp_valid=%b expected 00", resp_valid);
      end
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    last_model = NREQ - 1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Request scheduler that shares the single registered ALU (`alu_cpu`) between `NREQ` requesters over valid/ready handshakes. The scheduler arbitrates round-robin and drives the ALU operands and opcode. It waits out the ALU's one-cycle registered latency, then returns the result, a zero flag and an illegal-opcode flag to the winning requester. It sits between the CPU's issue logic and the ALU and is the only driver of the ALU inputs.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `WIDTH`, 32: operand/result width; must match the ALU.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept; at most one bit high.
- `req_a` in NREQ*WIDTH: operand A, requester i at bits [i*WIDTH +: WIDTH].
- `req_b` in NREQ*WIDTH: operand B, same packing.
- `req_op` in NREQ*3: opcode, requester i at [i*3 +: 3].
- `resp_valid` out NREQ: one-hot response valid to the granted requester.
- `resp_ready` in NREQ: per-requester response accept.
- `resp_result` out WIDTH: shared result bus.
- `resp_zero` out 1: `resp_result == 0`.
- `resp_illegal` out 1: opcode was not 000/001/010/011/111.
- `alu_a`, `alu_b` out WIDTH: to the ALU.
- `alu_control` out 3: to the ALU.
- `alu_result` in WIDTH: from the ALU; registered one cycle after its inputs.

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - The round-robin arbiter picks winner g among `req_valid`. Search starts at `last_grant+1` and wraps modulo NREQ.
  - `req_ready[g]=1` combinationally; all other `req_ready` bits are 0.
  - On the edge with any valid request: latch `req_a[g]`, `req_b[g]` and `req_op[g]` into the operand registers, latch `gnt_id=g`, set `last_grant=g`, go to EXEC.
- EXEC: operand registers drive the ALU, and the ALU samples them at this edge. Go to CAPT.
- CAPT: `alu_result` is valid. Capture it into `res_q`, set `zero_q=(alu_result==0)` and set `ill_q` from the latched opcode. Go to RESP.
- RESP:
  - `resp_valid[gnt_id]=1`. `resp_result`, `resp_zero` and `resp_illegal` stay stable.
  - On `resp_ready[gnt_id]` go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- `alu_a`, `alu_b` and `alu_control` always come from the operand registers. They change only on an IDLE accept.
- Illegal opcodes (100, 101, 110) are still issued. The ALU returns 0, so `resp_zero=1` and `resp_illegal=1`.
- No arithmetic in this block. The width of `resp_result` equals WIDTH, with no extension or truncation.
- `req_ready` is 0 in every state other than IDLE. Requesters hold `req_valid` and their payload until accepted.
- Requester payload is sampled only on the accept edge.
- Reset values:
  - FSM to IDLE.
  - `last_grant=NREQ-1`, so requester 0 wins first.
  - `gnt_id=0`.
  - Operand registers, `alu_control`, `res_q`, `zero_q` and `ill_q` to 0.
  - `resp_valid=0`, `req_ready` as the IDLE rule gives (0 while `rst` is high).

## Timing
- Accept on edge E0. EXEC during cycle 1, CAPT during cycle 2, `resp_valid` high from cycle 3.
- Minimum occupancy is 4 cycles per operation. The earliest next accept is the cycle after the response handshake, since RESP→IDLE costs one cycle.
- A response with `resp_ready` already high completes on the first RESP edge.
- Simultaneous requests: the grant goes to the first valid index after `last_grant`. Every requester that stays valid is served within NREQ operations.
- Requester withdrawing `req_valid` before accept: legal, nothing is latched.
- `rst` asserted in any state: next cycle is IDLE with the reset values above.
  - The in-flight operation is discarded and no response is issued.
  - The stale `alu_result` is ignored.
- `rst` has priority over all handshakes in the same cycle.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams `OP_AND=3'b000`, `OP_OR=3'b001`, `OP_ADD=3'b010`, `OP_SUB=3'b011`, `OP_MUL=3'b111`.
  - State typedef (IDLE/EXEC/CAPT/RESP).
  - Function `op_legal(op)`.
- Sub-module `rr_arbiter`, parameter NREQ:
  - Inputs: `req` and `last_grant`.
  - Outputs: one-hot `grant`, encoded `grant_id` and `any`.
  - Combinational, reusable by other shared resources.
- The FSM, operand/result registers and response muxing live in `alu_sched`.

## Test plan
- Single op: requester 0 sends ADD a=5, b=7 → `req_ready[0]` at accept, `resp_valid[0]` 3 cycles later, result=12, zero=0, illegal=0.
- Contention, NREQ=2: both hold valid from reset, req0 SUB 9-9, req1 OR 0xF0|0x0F → req0 served first with result=0, zero=1; then req1 with result=0xFF; then req0 again if still valid.
- Back-pressure: `resp_ready[1]` low for 5 cycles during a MUL 6*7 → `resp_valid[1]` and result=42 held stable for all 5 cycles, and `req_ready` stays 0.
- Illegal opcode 3'b101, a=3, b=4 → result=0, zero=1, illegal=1, FSM returns to IDLE normally.
- Reset mid-op: `rst` high during CAPT of ADD 1+1 → no `resp_valid` ever. The next request, AND 0xC&0xA, is granted to requester 0 with result=0x8.
